// File: rtl/cnn_axi_burst_slave.sv
// AXI4-full slave front end for the CNN core: CTRL/DATA/KERNEL/STATUS word map,
// INCR/FIXED bursts, pixel/result FIFO streaming and SLVERR on unsupported bursts.
module cnn_axi_burst_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int KERNEL_TAPS        = 9,
  parameter int KERNEL_WIDTH       = 8
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_areset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]          s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [7:0]                           s00_axi_awlen,
  input  logic [2:0]                           s00_axi_awsize,
  input  logic [1:0]                           s00_axi_awburst,
  input  logic                                 s00_axi_awvalid,
  output logic                                 s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
  input  logic                                 s00_axi_wlast,
  input  logic                                 s00_axi_wvalid,
  output logic                                 s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]          s00_axi_bid,
  output logic [1:0]                           s00_axi_bresp,
  output logic                                 s00_axi_bvalid,
  input  logic                                 s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [7:0]                           s00_axi_arlen,
  input  logic [2:0]                           s00_axi_arsize,
  input  logic [1:0]                           s00_axi_arburst,
  input  logic                                 s00_axi_arvalid,
  output logic                                 s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                           s00_axi_rresp,
  output logic                                 s00_axi_rlast,
  output logic                                 s00_axi_rvalid,
  input  logic                                 s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        pix_data,
  output logic                                 pix_valid,
  input  logic                                 pix_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        res_data,
  input  logic                                 res_valid,
  output logic                                 res_ready,
  output logic [KERNEL_TAPS*KERNEL_WIDTH-1:0]  kernel_taps,
  output logic                                 conv_start,
  input  logic                                 conv_busy,
  input  logic                                 conv_done
);

  localparam int         DW         = C_S_AXI_DATA_WIDTH;
  localparam logic [2:0] SIZE_MAX   = 3'($clog2(DW/8));
  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_DATA   = 2'd1;
  localparam logic [1:0] IDX_KERNEL = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] TAP_LAST   = 8'(KERNEL_TAPS-1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  logic [1:0] w_idx;
  logic [1:0] w_burst;
  logic       w_err;

  r_state_t r_state;
  logic [1:0] r_idx;
  logic [1:0] r_burst;
  logic       r_err;
  logic [7:0] r_len;
  logic [7:0] r_beat;

  logic [7:0]    tap_idx;
  logic          done_sticky;
  logic [DW-1:0] reg_rdata;

  logic aw_err;
  logic ar_err;
  logic w_fire;
  logic w_effect;
  logic r_fire;
  logic unused_inputs;

  assign unused_inputs = ^{s00_axi_awaddr, s00_axi_araddr, s00_axi_awlen};

  assign aw_err = (s00_axi_awsize > SIZE_MAX) || s00_axi_awburst[1];
  assign ar_err = (s00_axi_arsize > SIZE_MAX) || s00_axi_arburst[1];

  assign s00_axi_wready = (w_state == W_DATA) &&
                          (!((w_idx == IDX_DATA) && !w_err) || pix_ready);
  assign w_fire   = s00_axi_wvalid && s00_axi_wready;
  assign w_effect = w_fire && !w_err && (s00_axi_wstrb != '0);

  assign pix_data  = s00_axi_wdata;
  assign pix_valid = (w_state == W_DATA) && s00_axi_wvalid && (w_idx == IDX_DATA) &&
                     !w_err && (s00_axi_wstrb != '0);

  // Write channel sequencing: address capture, beat stepping, response hold
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state         <= W_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= 2'b00;
      s00_axi_bid     <= '0;
      w_idx           <= 2'd0;
      w_burst         <= 2'd0;
      w_err           <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s00_axi_awvalid && s00_axi_awready) begin
            w_state         <= W_DATA;
            s00_axi_awready <= 1'b0;
            s00_axi_bid     <= s00_axi_awid;
            w_idx           <= s00_axi_awaddr[3:2];
            w_burst         <= s00_axi_awburst;
            w_err           <= aw_err;
          end else begin
            s00_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_burst == BURST_INCR) w_idx <= w_idx + 2'd1;
            if (s00_axi_wlast) begin
              w_state        <= W_RESP;
              s00_axi_bvalid <= 1'b1;
              s00_axi_bresp  <= w_err ? 2'b10 : 2'b00;
            end
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            w_state         <= W_IDLE;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register side effects of accepted write beats: start pulse, done flag, kernel file
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      kernel_taps <= '0;
      tap_idx     <= 8'd0;
      conv_start  <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      conv_start <= w_effect && (w_idx == IDX_CTRL) && s00_axi_wdata[0] && !conv_busy;
      if (conv_done)
        done_sticky <= 1'b1;
      else if (w_effect && (w_idx == IDX_CTRL) && s00_axi_wdata[1])
        done_sticky <= 1'b0;
      if (w_effect && (w_idx == IDX_KERNEL)) begin
        for (int i = 0; i < KERNEL_TAPS; i++) begin
          if (tap_idx == 8'(i))
            kernel_taps[i*KERNEL_WIDTH +: KERNEL_WIDTH] <= s00_axi_wdata[KERNEL_WIDTH-1:0];
        end
        tap_idx <= (tap_idx == TAP_LAST) ? 8'd0 : tap_idx + 8'd1;
      end
    end
  end

  // Read channel sequencing: address capture, beat counting, burst completion
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      r_idx           <= 2'd0;
      r_burst         <= 2'd0;
      r_err           <= 1'b0;
      r_len           <= 8'd0;
      r_beat          <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi_arvalid && s00_axi_arready) begin
            r_state         <= R_DATA;
            s00_axi_arready <= 1'b0;
            r_idx           <= s00_axi_araddr[3:2];
            r_burst         <= s00_axi_arburst;
            r_err           <= ar_err;
            r_len           <= s00_axi_arlen;
            r_beat          <= 8'd0;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (r_burst == BURST_INCR) r_idx <= r_idx + 2'd1;
            r_beat <= r_beat + 8'd1;
            if (s00_axi_rlast) begin
              r_state         <= R_IDLE;
              s00_axi_arready <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Readable register view for the non-streaming word slots
  always_comb begin
    reg_rdata = '0;
    case (r_idx)
      IDX_KERNEL: reg_rdata[7:0] = tap_idx;
      IDX_STATUS: begin
        reg_rdata[0]    = conv_busy;
        reg_rdata[1]    = done_sticky;
        reg_rdata[2]    = !pix_ready;
        reg_rdata[3]    = !res_valid;
        reg_rdata[15:8] = tap_idx;
      end
      default: reg_rdata = '0;
    endcase
  end

  // Read data mux: error beats, result FIFO pass-through or register value
  always_comb begin
    s00_axi_rvalid = 1'b0;
    s00_axi_rdata  = '0;
    s00_axi_rresp  = 2'b00;
    if (r_state == R_DATA) begin
      if (r_err) begin
        s00_axi_rvalid = 1'b1;
        s00_axi_rresp  = 2'b10;
      end else if (r_idx == IDX_DATA) begin
        s00_axi_rvalid = res_valid;
        s00_axi_rdata  = res_data;
      end else begin
        s00_axi_rvalid = 1'b1;
        s00_axi_rdata  = reg_rdata;
      end
    end
  end

  assign s00_axi_rlast = (r_state == R_DATA) && (r_beat == r_len);
  assign r_fire        = s00_axi_rvalid && s00_axi_rready;
  assign res_ready     = (r_state == R_DATA) && !r_err && (r_idx == IDX_DATA) &&
                         res_valid && s00_axi_rready;

endmodule

// File: doc/cnn_axi_burst_slave.md
Name: cnn_axi_burst_slave

Overview:
- Parametrised AXI4-full slave front end for the CNN IP core: a control register, a streaming data port, kernel coefficient loading and a status register behind a 4-word address map.
- Adds INCR/FIXED burst support, ready/valid streaming with backpressure to the pixel and result FIFOs, a parametrised kernel register file, and SLVERR signalling.
- Sits between the PS AXI interconnect and the convolution engine and its FIFOs.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, AXI address width; only addr[3:2] is decoded.
- C_S_AXI_ID_WIDTH, 1, AXI ID width.
- KERNEL_TAPS, 9, number of kernel coefficients (K*K); 1..255.
- KERNEL_WIDTH, 8, bits per coefficient; <= C_S_AXI_DATA_WIDTH.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  synchronous reset, active-high
- s00_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID/ADDR/8/3/2/1  write address channel
- s00_axi_awready  out  1
- s00_axi_wdata/wstrb/wlast/wvalid  in  DW/DW/8/1/1  write data channel
- s00_axi_wready  out  1
- s00_axi_bid/bresp/bvalid  out  ID/2/1; s00_axi_bready in 1  write response channel
- s00_axi_araddr/arlen/arsize/arburst/arvalid  in  ADDR/8/3/2/1  read address channel
- s00_axi_arready  out  1
- s00_axi_rdata/rresp/rlast/rvalid  out  DW/2/1/1; s00_axi_rready in 1  read data channel
- pix_data  out  DW  pixel word to the input FIFO
- pix_valid  out  1; pix_ready in 1  pixel push handshake
- res_data  in  DW  result word from the output FIFO
- res_valid  in  1; res_ready out 1  result pop handshake
- kernel_taps  out  KERNEL_TAPS*KERNEL_WIDTH  flattened coefficients; tap 0 in the LSBs
- conv_start  out  1  one-cycle start pulse
- conv_busy, conv_done  in  1, 1  engine status; conv_done is a one-cycle pulse

Behaviour:
- Address map (word index addr[3:2]):
  - 0 CTRL: write bit0 = start, bit1 = W1C done; reads 0.
  - 1 DATA: write pushes to the pixel FIFO; read pops from the result FIFO.
  - 2 KERNEL: each write beat stores wdata[KERNEL_WIDTH-1:0] at tap_idx, then tap_idx++; after KERNEL_TAPS-1 it wraps to 0. Reads return {tap_idx} zero-extended.
  - 3 STATUS (read-only): bit0 conv_busy, bit1 done_sticky, bit2 !pix_ready, bit3 !res_valid, bits[15:8] tap_idx. Writes are ignored and respond OKAY.
- Reset: every output 0; awready = arready = 0 during reset, 1 the cycle after. kernel_taps = 0, tap_idx = 0, done_sticky = 0, FSMs idle. Reset mid-burst aborts the burst immediately, with no response issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - awready = (state == W_IDLE). The AW handshake captures id, addr, len, size, burst.
  - err = (awsize > log2(DW/8)) or (awburst == WRAP or reserved).
  - In W_DATA: wready = !(target == DATA && !err) || pix_ready.
  - pix_valid = W_DATA && wvalid && target == DATA && !err && (wstrb != 0); pix_data = wdata, combinational pass-through.
  - A beat with wstrb == 0 or err is consumed with no side effect.
  - Beat address: INCR adds 1 to the word index mod 4 per beat; FIXED holds it.
  - After the beat with wlast: W_RESP, bvalid = 1 held until bready; bresp = 10 if err else 00; bid = captured id.
- conv_start: registered; pulses 1 cycle after an accepted CTRL beat with wdata[0] = 1 and !err, only if conv_busy = 0. Otherwise it is dropped.
- done_sticky: set by conv_done, cleared by a CTRL write with bit1 = 1. Simultaneous set and clear -> set wins.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - arready = (state == R_IDLE). err rule and address stepping are the same as for writes.
  - R_DATA, target DATA and !err: rvalid = res_valid, rdata = res_data, res_ready = rvalid && rready.
  - Other targets: rvalid = 1, rdata = register value.
  - err: rvalid = 1, rdata = 0, rresp = 10, no pop.
  - rlast = (beat_cnt == arlen). Return to R_IDLE on rlast && rready.
- Read and write FSMs are independent and may run concurrently. A kernel write and a STATUS read in the same cycle return the pre-write tap_idx.

Test Plan:
- Reset, then a single INCR write of CTRL = 0x1 with conv_busy = 0 -> conv_start high exactly 1 cycle after the W handshake; bresp = 00; bid echoes awid = 1.
- FIXED burst to DATA, awlen = 3, words 0x03020100..0x0F0E0D0C, pix_ready low 2 cycles on beat 2 -> 4 pushes in order; wready follows pix_ready; one bvalid after wlast.
- 10 single writes to KERNEL of 0..9 with KERNEL_TAPS = 9 -> taps 1..8 at index 1..8, tap0 = 9; STATUS[15:8] = 1.
- FIXED read burst of DATA, arlen = 3, res_valid toggling -> 4 beats equal to res_data, rlast only on beat 4, exactly 4 res_ready pulses.
- WRAP-burst write to DATA, awlen = 1 -> 2 beats consumed, no pix_valid, bresp = 10. awsize = 3 read at DW = 32 -> rresp = 10, rdata = 0.
- conv_done pulse, then a CTRL write of 0x2 in the same cycle as a second conv_done -> STATUS bit1 stays 1. A later 0x2 write -> 0. Reset asserted mid-burst -> bvalid never asserted, awready = 1 the cycle after reset drops.
